// File: rtl/cv32e40p_ft_breakage_mon_if.sv
// Bus bundle between the TMR voters/controller and the breakage monitor.
// The slave modport is the monitor's view and the master modport is the driver's view.
interface cv32e40p_ft_breakage_mon_if #(
  parameter int unsigned N_CH      = 3,
  parameter int unsigned COUNT_BIT = 8
) ();
  localparam int unsigned CH_W = $clog2(N_CH);

  logic                      valid_i;
  logic [N_CH-1:0]           err_i;
  logic [N_CH-1:0]           clear_i;
  logic [N_CH-1:0]           broken_o;
  logic [N_CH*COUNT_BIT-1:0] count_o;
  logic                      fatal_o;
  logic                      evt_valid_o;
  logic [CH_W-1:0]           evt_ch_o;
  logic                      evt_ready_i;

  modport slave (
    input  valid_i, err_i, clear_i, evt_ready_i,
    output broken_o, count_o, fatal_o, evt_valid_o, evt_ch_o
  );

  modport master (
    output valid_i, err_i, clear_i, evt_ready_i,
    input  broken_o, count_o, fatal_o, evt_valid_o, evt_ch_o
  );
endinterface

// File: rtl/cv32e40p_ft_breakage_mon.sv
// Per-replica saturating error counters with HEALTHY/SUSPECT/BROKEN tracking.
// Each break is reported once through a pending mask, lowest channel first; fatal_o flags too few healthy replicas.
module cv32e40p_ft_breakage_mon #(
  parameter int unsigned N_CH               = 3,
  parameter int unsigned COUNT_BIT          = 8,
  parameter int unsigned INC_DEC_BIT        = 2,
  parameter int unsigned INCREMENT          = 1,
  parameter int unsigned DECREMENT          = 1,
  parameter int unsigned BREAKING_THRESHOLD = 3,
  parameter bit          STICKY             = 1'b1,
  parameter int unsigned RECOVER_THRESHOLD  = 0,
  parameter int unsigned FATAL_COUNT        = 2
) (
  input logic clk,
  input logic rst_n,
  cv32e40p_ft_breakage_mon_if.slave bus
);
  localparam int unsigned CH_W = $clog2(N_CH);
  localparam logic [INC_DEC_BIT-1:0] INC_V = INC_DEC_BIT'(INCREMENT);
  localparam logic [INC_DEC_BIT-1:0] DEC_V = INC_DEC_BIT'(DECREMENT);
  // One guard bit so the increment can overshoot before it is saturated.
  localparam logic [COUNT_BIT:0] CNT_MAX = {1'b0, {COUNT_BIT{1'b1}}};
  localparam logic [COUNT_BIT:0] INC_W   = (COUNT_BIT+1)'(INC_V);
  localparam logic [COUNT_BIT:0] DEC_W   = (COUNT_BIT+1)'(DEC_V);
  localparam logic [COUNT_BIT:0] THR_W   = (COUNT_BIT+1)'(BREAKING_THRESHOLD);
  localparam logic [COUNT_BIT:0] REC_W   = (COUNT_BIT+1)'(RECOVER_THRESHOLD);

  typedef enum logic [1:0] {StHealthy, StSuspect, StBroken} state_e;

  state_e               r_state   [N_CH];
  state_e               w_state_d [N_CH];
  logic [COUNT_BIT-1:0] r_cnt     [N_CH];
  logic [COUNT_BIT-1:0] w_cnt_d   [N_CH];
  logic [COUNT_BIT:0]   w_sum     [N_CH];
  logic [N_CH-1:0]      r_pend, w_pend_d, w_enter, w_broken_d, w_hs_mask;
  logic [CH_W-1:0]      w_evt_ch;
  logic                 r_fatal, w_fatal_d;
  int unsigned          w_nbroken;

  always_comb begin
    w_enter    = '0;
    w_broken_d = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_sum[k]     = {1'b0, r_cnt[k]};
      w_cnt_d[k]   = r_cnt[k];
      w_state_d[k] = r_state[k];
      if (bus.clear_i[k]) begin
        w_cnt_d[k]   = '0;
        w_state_d[k] = StHealthy;
      end else if (bus.valid_i && !(STICKY && r_state[k] == StBroken)) begin
        if (bus.err_i[k]) begin
          w_sum[k] = {1'b0, r_cnt[k]} + INC_W;
          if (w_sum[k] > CNT_MAX) w_sum[k] = CNT_MAX;
        end else begin
          w_sum[k] = ({1'b0, r_cnt[k]} >= DEC_W) ? ({1'b0, r_cnt[k]} - DEC_W) : '0;
        end
        w_cnt_d[k] = w_sum[k][COUNT_BIT-1:0];
        if (r_state[k] == StBroken) begin
          if (w_sum[k] <= REC_W) w_state_d[k] = (w_sum[k] == '0) ? StHealthy : StSuspect;
        end else if (w_sum[k] >= THR_W) begin
          w_state_d[k] = StBroken;
        end else begin
          w_state_d[k] = (w_sum[k] == '0) ? StHealthy : StSuspect;
        end
      end
      w_broken_d[k] = (w_state_d[k] == StBroken);
      w_enter[k]    = w_broken_d[k] && (r_state[k] != StBroken);
    end
  end

  // Lowest pending channel is reported; a handshake retires exactly that one.
  always_comb begin
    w_evt_ch  = '0;
    w_hs_mask = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (r_pend[k]) w_evt_ch = CH_W'(k);
    end
    if (|r_pend && bus.evt_ready_i) w_hs_mask = {{(N_CH-1){1'b0}}, 1'b1} << w_evt_ch;
    w_pend_d  = (r_pend & ~w_hs_mask & ~bus.clear_i) | w_enter;
    w_nbroken = 0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_broken_d[k]) w_nbroken = w_nbroken + 1;
    end
    w_fatal_d = (w_nbroken >= FATAL_COUNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        r_state[k] <= StHealthy;
        r_cnt[k]   <= '0;
      end
      r_pend  <= '0;
      r_fatal <= 1'b0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        r_state[k] <= w_state_d[k];
        r_cnt[k]   <= w_cnt_d[k];
      end
      r_pend  <= w_pend_d;
      r_fatal <= w_fatal_d;
    end
  end

  always_comb begin
    bus.broken_o = '0;
    bus.count_o  = '0;
    for (int k = 0; k < N_CH; k++) begin
      bus.broken_o[k]                         = (r_state[k] == StBroken);
      bus.count_o[k*COUNT_BIT +: COUNT_BIT]   = r_cnt[k];
    end
    bus.fatal_o     = r_fatal;
    bus.evt_valid_o = |r_pend;
    bus.evt_ch_o    = w_evt_ch;
  end
endmodule

// File: tb/tb_cv32e40p_ft_breakage_mon.sv
// Bench for the breakage monitor: vector table, directed corner sequences, and randomized votes
// checked against an integer model of the counting and reporting rules.
module tb_cv32e40p_ft_breakage_mon;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cv32e40p_ft_breakage_mon_if #(.N_CH(3), .COUNT_BIT(8)) bus1 ();
  cv32e40p_ft_breakage_mon_if #(.N_CH(3), .COUNT_BIT(2)) bus2 ();

  cv32e40p_ft_breakage_mon #(.N_CH(3), .COUNT_BIT(8)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  cv32e40p_ft_breakage_mon #(
    .N_CH              (3),
    .COUNT_BIT         (2),
    .STICKY            (1'b0),
    .RECOVER_THRESHOLD (1)
  ) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit [2:0] e, input bit [2:0] c, input bit r);
    bus1.valid_i = v; bus1.err_i = e; bus1.clear_i = c; bus1.evt_ready_i = r;
    bus2.valid_i = v; bus2.err_i = e; bus2.clear_i = c; bus2.evt_ready_i = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 3'b000, 3'b000, 1'b0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic int dut_cnt(input bit sel2, input int k);
    if (sel2) return int'(bus2.count_o[k*2 +: 2]);
    return int'(bus1.count_o[k*8 +: 8]);
  endfunction

  // Vector table
  typedef struct {
    bit v; bit [2:0] e; bit [2:0] c; bit r;
    logic [23:0] cnt; logic [2:0] brk; bit ev; logic [1:0] ch; bit fat;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input bit v, input bit [2:0] e, input bit [2:0] c, input bit r,
                              input logic [23:0] cnt, input logic [2:0] brk, input bit ev,
                              input logic [1:0] ch, input bit fat);
    vec_t t;
    t.v = v; t.e = e; t.c = c; t.r = r;
    t.cnt = cnt; t.brk = brk; t.ev = ev; t.ch = ch; t.fat = fat;
    return t;
  endfunction

  // Reference model: plain integers and flags, one entry per channel
  int unsigned cfg_max, cfg_thr, cfg_rec;
  bit          cfg_sticky;
  int          m_cnt [3];
  bit          m_brk [3];
  bit          m_pend[3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_brk[k] = 1'b0; m_pend[k] = 1'b0;
    end
  endtask

  function automatic int model_low();
    for (int k = 0; k < 3; k++) if (m_pend[k]) return k;
    return -1;
  endfunction

  task automatic model_step(input bit v, input bit [2:0] e, input bit [2:0] c, input bit r);
    int lo;
    lo = model_low();
    if (r && lo >= 0) m_pend[lo] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (c[k]) begin
        m_cnt[k] = 0; m_brk[k] = 1'b0; m_pend[k] = 1'b0;
      end else if (v && !(m_brk[k] && cfg_sticky)) begin
        if (e[k]) m_cnt[k] = (m_cnt[k] + 1 > int'(cfg_max)) ? int'(cfg_max) : m_cnt[k] + 1;
        else      m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
        if (!m_brk[k] && m_cnt[k] >= int'(cfg_thr)) begin
          m_brk[k] = 1'b1; m_pend[k] = 1'b1;
        end else if (m_brk[k] && !cfg_sticky && m_cnt[k] <= int'(cfg_rec)) begin
          m_brk[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic model_check(input bit sel2);
    int nb;
    int lo;
    logic [2:0] brk;
    nb = 0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rnd%0d_cnt%0d", sel2 + 1, k), 32'(dut_cnt(sel2, k)), 32'(m_cnt[k]));
      if (m_brk[k]) nb++;
    end
    brk = {m_brk[2], m_brk[1], m_brk[0]};
    lo  = model_low();
    chk($sformatf("rnd%0d_broken", sel2 + 1), sel2 ? 32'(bus2.broken_o) : 32'(bus1.broken_o),
        32'(brk));
    chk($sformatf("rnd%0d_fatal", sel2 + 1), sel2 ? 32'(bus2.fatal_o) : 32'(bus1.fatal_o),
        32'(nb >= 2));
    chk($sformatf("rnd%0d_evt_valid", sel2 + 1),
        sel2 ? 32'(bus2.evt_valid_o) : 32'(bus1.evt_valid_o), 32'(lo >= 0));
    chk($sformatf("rnd%0d_evt_ch", sel2 + 1), sel2 ? 32'(bus2.evt_ch_o) : 32'(bus1.evt_ch_o),
        (lo >= 0) ? 32'(lo) : 32'd0);
  endtask

  task automatic random_run(input bit sel2, input int cycles);
    bit v; bit [2:0] e; bit [2:0] c; bit r;
    do_reset();
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      v = ($urandom_range(3) != 0);
      e = 3'($urandom_range(7));
      c = '0;
      for (int k = 0; k < 3; k++) c[k] = ($urandom_range(19) == 0);
      r = $urandom_range(1) == 1;
      drive(v, e, c, r);
      step();
      model_step(v, e, c, r);
      model_check(sel2);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset defaults and clean votes
    do_reset();
    chk("rst_broken", 32'(bus1.broken_o), 32'd0);
    chk("rst_count", 32'(bus1.count_o), 32'd0);
    chk("rst_fatal", 32'(bus1.fatal_o), 32'd0);
    chk("rst_evt_valid", 32'(bus1.evt_valid_o), 32'd0);
    chk("rst_evt_ch", 32'(bus1.evt_ch_o), 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'b000, 3'b000, 1'b0);
      step();
      chk("clean_count", 32'(bus1.count_o), 32'd0);
    end

    // Table: single break with stalled consumer, dual break -> fatal, clear on broken channel
    tbl.push_back(mk(1, 3'b010, 3'b000, 0, 24'h000100, 3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 3'b010, 3'b000, 0, 24'h000200, 3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 3'b010, 3'b000, 0, 24'h000300, 3'b010, 1, 1, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 3'b000, 3'b000, 0, 24'h000300, 3'b010, 1, 1, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 1, 24'h000300, 3'b010, 0, 0, 0));
    tbl.push_back(mk(1, 3'b010, 3'b010, 0, 24'h000000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 3'b101, 3'b000, 1, 24'h010001, 3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 3'b101, 3'b000, 1, 24'h020002, 3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 3'b101, 3'b000, 1, 24'h030003, 3'b101, 1, 0, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 1, 24'h030003, 3'b101, 1, 2, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, 1, 24'h030003, 3'b101, 0, 0, 1));
    tbl.push_back(mk(0, 3'b000, 3'b101, 0, 24'h000000, 3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 3'b010, 3'b000, 0, 24'h000100, 3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 3'b010, 3'b000, 0, 24'h000200, 3'b000, 0, 0, 0));
    tbl.push_back(mk(1, 3'b010, 3'b000, 0, 24'h000300, 3'b010, 1, 1, 0));
    tbl.push_back(mk(1, 3'b010, 3'b010, 0, 24'h000000, 3'b000, 0, 0, 0));
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].e, tbl[i].c, tbl[i].r);
      step();
      chk($sformatf("tbl%0d_count", i), 32'(bus1.count_o), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_broken", i), 32'(bus1.broken_o), 32'(tbl[i].brk));
      chk($sformatf("tbl%0d_evt_valid", i), 32'(bus1.evt_valid_o), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_evt_ch", i), 32'(bus1.evt_ch_o), 32'(tbl[i].ch));
      chk($sformatf("tbl%0d_fatal", i), 32'(bus1.fatal_o), 32'(tbl[i].fat));
    end

    // Alternating err/ok on ch0 never reaches threshold
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, (i % 2 == 0) ? 3'b001 : 3'b000, 3'b000, 1'b0);
      step();
      chk("alt_count0", 32'(dut_cnt(1'b0, 0)), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_broken0", 32'(bus1.broken_o[0]), 32'd0);
    end

    // Narrow hysteretic instance: saturation then recovery, report kept
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'b100, 3'b000, 1'b0);
      step();
      chk("hyst_sat_count2", 32'(dut_cnt(1'b1, 2)), (i >= 2) ? 32'd3 : 32'(i + 1));
      chk("hyst_sat_broken2", 32'(bus2.broken_o[2]), (i >= 2) ? 32'd1 : 32'd0);
    end
    drive(1'b1, 3'b000, 3'b000, 1'b0);
    step();
    chk("hyst_rec1_count2", 32'(dut_cnt(1'b1, 2)), 32'd2);
    chk("hyst_rec1_broken2", 32'(bus2.broken_o[2]), 32'd1);
    step();
    chk("hyst_rec2_count2", 32'(dut_cnt(1'b1, 2)), 32'd1);
    chk("hyst_rec2_broken2", 32'(bus2.broken_o[2]), 32'd0);
    chk("hyst_evt_valid", 32'(bus2.evt_valid_o), 32'd1);
    chk("hyst_evt_ch", 32'(bus2.evt_ch_o), 32'd2);

    // Asynchronous reset mid-cycle with events pending
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b101, 3'b000, 1'b0);
      step();
    end
    drive(1'b0, 3'b000, 3'b000, 1'b0);
    chk("pre_arst_evt_valid", 32'(bus1.evt_valid_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_evt_valid", 32'(bus1.evt_valid_o), 32'd0);
    chk("arst_broken", 32'(bus1.broken_o), 32'd0);
    chk("arst_count", 32'(bus1.count_o), 32'd0);
    chk("arst_fatal", 32'(bus1.fatal_o), 32'd0);
    #2;
    rst_n = 1'b1;
    step();

    // Randomized votes against the model, sticky and hysteretic instances
    cfg_max = 255; cfg_thr = 3; cfg_rec = 0; cfg_sticky = 1'b1;
    random_run(1'b0, 400);
    cfg_max = 3; cfg_thr = 3; cfg_rec = 1; cfg_sticky = 1'b0;
    random_run(1'b1, 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
